fetch_stage: RTL and testbench

- Instruction-fetch stage of the 19-bit pipelined CPU, directly downstream of the pc register.
- Consumes the current `pc` and issues one instruction-memory request at a time.
- Loads the returned instruction into the IF/ID pipeline register.
- Drives `next_pc`/`pcwrite` back into the pc register. Handles decode stall and branch/jump redirect (flush).

---
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: pc register handshake, instruction memory port, and IF/ID outputs.
interface fetch_stage_if #(
  parameter int unsigned XLEN = 19
);
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            pcwrite;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            ifid_valid;
  logic [XLEN-1:0] ifid_instr;
  logic [XLEN-1:0] ifid_pc;

  modport master (
    input  pc, imem_ready, imem_rvalid, imem_rdata, stall, redirect, redirect_pc,
    output next_pc, pcwrite, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc
  );

  modport slave (
    output pc, imem_ready, imem_rvalid, imem_rdata, stall, redirect, redirect_pc,
    input  next_pc, pcwrite, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request, skid buffer for a stalled
// decode stage, redirect/flush handling, and the IF/ID pipeline register.
module fetch_stage #(
  parameter int unsigned    XLEN      = 19,
  parameter logic [XLEN-1:0] PC_INC    = 1,
  parameter logic [XLEN-1:0] NOP_INSTR = '0
) (
  input logic              clk,
  input logic              reset,
  fetch_stage_if.master    bus
);

  typedef enum logic [1:0] {StFetch, StWait, StHold, StDrain} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fa_q, fa_d;
  logic [XLEN-1:0] skid_q, skid_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;

  logic            can_accept;
  logic            imem_req;
  logic            pcwrite;
  logic [XLEN-1:0] next_pc;

  assign can_accept = !vld_q || !bus.stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      fa_q    <= '0;
      skid_q  <= '0;
      vld_q   <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      skid_q  <= skid_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fa_d     = fa_q;
    skid_d   = skid_q;
    vld_d    = vld_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    imem_req = 1'b0;
    pcwrite  = 1'b0;
    next_pc  = fa_q + PC_INC;

    if (bus.redirect) begin
      // Redirect wins over everything: flush IF/ID and abandon any in-flight data.
      pcwrite = 1'b1;
      next_pc = bus.redirect_pc;
      vld_d   = 1'b0;
      instr_d = NOP_INSTR;
      unique case (state_q)
        StFetch: state_d = StFetch;
        StWait:  state_d = bus.imem_rvalid ? StFetch : StDrain;
        StHold:  state_d = StFetch;
        StDrain: state_d = StDrain;
        default: state_d = StFetch;
      endcase
    end else begin
      if (vld_q && !bus.stall) vld_d = 1'b0;
      unique case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          if (bus.imem_ready) begin
            fa_d    = bus.pc;
            state_d = StWait;
          end
        end
        StWait: begin
          if (bus.imem_rvalid) begin
            if (can_accept) begin
              vld_d   = 1'b1;
              instr_d = bus.imem_rdata;
              ipc_d   = fa_q;
              pcwrite = 1'b1;
              state_d = StFetch;
            end else begin
              skid_d  = bus.imem_rdata;
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (can_accept) begin
            vld_d   = 1'b1;
            instr_d = skid_q;
            ipc_d   = fa_q;
            pcwrite = 1'b1;
            state_d = StFetch;
          end
        end
        StDrain: begin
          if (bus.imem_rvalid) state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // Every output is held at zero while reset is asserted.
  assign bus.imem_req   = reset & imem_req;
  assign bus.pcwrite    = reset & pcwrite;
  assign bus.next_pc    = reset ? next_pc : '0;
  assign bus.imem_addr  = reset ? bus.pc : '0;
  assign bus.ifid_valid = vld_q;
  assign bus.ifid_instr = instr_q;
  assign bus.ifid_pc    = ipc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus an async-reset sequence.
module tb_fetch_stage;
  localparam int unsigned XLEN = 19;
  typedef logic [XLEN-1:0] w_t;

  typedef struct {
    logic rst;
    w_t   pc;
    logic rdy;
    logic rv;
    w_t   rd;
    logic st;
    logic redir;
    w_t   rpc;
    logic e_req;
    w_t   e_addr;
    logic e_pw;
    w_t   e_npc;
    logic e_v;
    w_t   e_instr;
    w_t   e_ipc;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs[23];

  fetch_stage_if #(.XLEN(XLEN)) bus ();

  fetch_stage #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, w_t pc, logic rdy, logic rv, w_t rd, logic st,
                              logic redir, w_t rpc, logic e_req, w_t e_addr, logic e_pw,
                              w_t e_npc, logic e_v, w_t e_instr, w_t e_ipc);
    vec_t v;
    v.rst = rst; v.pc = pc; v.rdy = rdy; v.rv = rv; v.rd = rd; v.st = st;
    v.redir = redir; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr; v.e_pw = e_pw;
    v.e_npc = e_npc; v.e_v = e_v; v.e_instr = e_instr; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic chk(input string name, input w_t act, input w_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input w_t pc, input logic rdy, input logic rv,
                       input w_t rd, input logic st, input logic redir, input w_t rpc);
    reset           = rst;
    bus.pc          = pc;
    bus.imem_ready  = rdy;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.stall       = st;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  task automatic chk_all(input string tag, input logic e_req, input w_t e_addr, input logic e_pw,
                         input w_t e_npc, input logic e_v, input w_t e_instr, input w_t e_ipc);
    chk({tag, ".imem_req"}, w_t'(bus.imem_req), w_t'(e_req));
    chk({tag, ".imem_addr"}, bus.imem_addr, e_addr);
    chk({tag, ".pcwrite"}, w_t'(bus.pcwrite), w_t'(e_pw));
    chk({tag, ".next_pc"}, bus.next_pc, e_npc);
    chk({tag, ".ifid_valid"}, w_t'(bus.ifid_valid), w_t'(e_v));
    chk({tag, ".ifid_instr"}, bus.ifid_instr, e_instr);
    chk({tag, ".ifid_pc"}, bus.ifid_pc, e_ipc);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b0, 19'h00010, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

    //           rst pc        rdy rv rd        st rdr rpc       req addr      pw npc       v instr     ipc
    vecs[0]  = mk(0, 19'h00010, 0, 0, 19'h00000, 0, 0, 19'h00000, 0, 19'h00000, 0, 19'h00000, 0, 19'h00000, 19'h00000);
    vecs[1]  = mk(0, 19'h00010, 1, 0, 19'h00000, 0, 0, 19'h00000, 0, 19'h00000, 0, 19'h00000, 0, 19'h00000, 19'h00000);
    vecs[2]  = mk(0, 19'h00010, 1, 0, 19'h00000, 0, 0, 19'h00000, 0, 19'h00000, 0, 19'h00000, 0, 19'h00000, 19'h00000);
    vecs[3]  = mk(1, 19'h00010, 1, 0, 19'h00000, 0, 0, 19'h00000, 1, 19'h00010, 0, 19'h00001, 0, 19'h00000, 19'h00000);
    vecs[4]  = mk(1, 19'h00010, 1, 1, 19'h12345, 0, 0, 19'h00000, 0, 19'h00010, 1, 19'h00011, 0, 19'h00000, 19'h00000);
    vecs[5]  = mk(1, 19'h00011, 1, 0, 19'h00000, 1, 0, 19'h00000, 1, 19'h00011, 0, 19'h00011, 1, 19'h12345, 19'h00010);
    vecs[6]  = mk(1, 19'h00011, 1, 1, 19'h2AAAA, 1, 0, 19'h00000, 0, 19'h00011, 0, 19'h00012, 1, 19'h12345, 19'h00010);
    vecs[7]  = mk(1, 19'h00011, 1, 0, 19'h00000, 1, 0, 19'h00000, 0, 19'h00011, 0, 19'h00012, 1, 19'h12345, 19'h00010);
    vecs[8]  = mk(1, 19'h00011, 1, 0, 19'h00000, 0, 0, 19'h00000, 0, 19'h00011, 1, 19'h00012, 1, 19'h12345, 19'h00010);
    vecs[9]  = mk(1, 19'h00012, 1, 0, 19'h00000, 0, 0, 19'h00000, 1, 19'h00012, 0, 19'h00012, 1, 19'h2AAAA, 19'h00011);
    vecs[10] = mk(1, 19'h00012, 1, 0, 19'h00000, 0, 1, 19'h00040, 0, 19'h00012, 1, 19'h00040, 0, 19'h2AAAA, 19'h00011);
    vecs[11] = mk(1, 19'h00040, 1, 1, 19'h11111, 0, 0, 19'h00000, 0, 19'h00040, 0, 19'h00013, 0, 19'h00000, 19'h00011);
    vecs[12] = mk(1, 19'h00040, 1, 0, 19'h00000, 0, 0, 19'h00000, 1, 19'h00040, 0, 19'h00013, 0, 19'h00000, 19'h00011);
    vecs[13] = mk(1, 19'h00040, 1, 1, 19'h22222, 0, 1, 19'h00050, 0, 19'h00040, 1, 19'h00050, 0, 19'h00000, 19'h00011);
    vecs[14] = mk(1, 19'h00050, 0, 0, 19'h00000, 0, 0, 19'h00000, 1, 19'h00050, 0, 19'h00041, 0, 19'h00000, 19'h00011);
    vecs[15] = mk(1, 19'h7FFFF, 1, 0, 19'h00000, 0, 0, 19'h00000, 1, 19'h7FFFF, 0, 19'h00041, 0, 19'h00000, 19'h00011);
    vecs[16] = mk(1, 19'h7FFFF, 1, 1, 19'h33333, 0, 0, 19'h00000, 0, 19'h7FFFF, 1, 19'h00000, 0, 19'h00000, 19'h00011);
    vecs[17] = mk(1, 19'h00000, 1, 0, 19'h00000, 1, 0, 19'h00000, 1, 19'h00000, 0, 19'h00000, 1, 19'h33333, 19'h7FFFF);
    vecs[18] = mk(1, 19'h00000, 1, 0, 19'h00000, 1, 0, 19'h00000, 0, 19'h00000, 0, 19'h00001, 1, 19'h33333, 19'h7FFFF);
    vecs[19] = mk(1, 19'h00000, 1, 1, 19'h55555, 1, 0, 19'h00000, 0, 19'h00000, 0, 19'h00001, 1, 19'h33333, 19'h7FFFF);
    vecs[20] = mk(1, 19'h00000, 1, 0, 19'h00000, 1, 1, 19'h00060, 0, 19'h00000, 1, 19'h00060, 1, 19'h33333, 19'h7FFFF);
    vecs[21] = mk(1, 19'h00060, 0, 0, 19'h00000, 0, 0, 19'h00000, 1, 19'h00060, 0, 19'h00001, 0, 19'h00000, 19'h7FFFF);
    vecs[22] = mk(1, 19'h00060, 1, 0, 19'h00000, 0, 0, 19'h00000, 1, 19'h00060, 0, 19'h00001, 0, 19'h00000, 19'h7FFFF);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].pc, vecs[i].rdy, vecs[i].rv, vecs[i].rd, vecs[i].st,
            vecs[i].redir, vecs[i].rpc);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pw,
              vecs[i].e_npc, vecs[i].e_v, vecs[i].e_instr, vecs[i].e_ipc);
    end

    // Now in WAIT for address 00060: assert reset between clock edges.
    @(posedge clk);
    #2;
    drive(1'b0, 19'h00060, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    #1;
    chk_all("async_rst", 1'b0, 19'h00000, 1'b0, 19'h00000, 1'b0, 19'h00000, 19'h00000);
    @(posedge clk);
    @(negedge clk);
    // Late response arrives right after release; it must be ignored in FETCH.
    drive(1'b1, 19'h00020, 1'b0, 1'b1, 19'h44444, 1'b0, 1'b0, '0);
    #1;
    chk_all("post_rst0", 1'b1, 19'h00020, 1'b0, 19'h00001, 1'b0, 19'h00000, 19'h00000);
    @(negedge clk);
    drive(1'b1, 19'h00020, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    #1;
    chk_all("post_rst1", 1'b1, 19'h00020, 1'b0, 19'h00001, 1'b0, 19'h00000, 19'h00000);
    @(negedge clk);
    drive(1'b1, 19'h00020, 1'b1, 1'b1, 19'h44444, 1'b0, 1'b0, '0);
    #1;
    chk_all("post_rst2", 1'b0, 19'h00020, 1'b1, 19'h00021, 1'b0, 19'h00000, 19'h00000);
    @(negedge clk);
    drive(1'b1, 19'h00021, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    #1;
    chk_all("post_rst3", 1'b1, 19'h00021, 1'b0, 19'h00021, 1'b1, 19'h44444, 19'h00020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
